multi_key_debouncer: RTL and testbench
======================================

// Module: multi_key_debouncer
// PURPOSE
//  - N-channel successor to the single-key debouncer.
//  - Per channel: sync async key inputs, filter glitches shorter than GLITCH_TIME_NS.
//  - Outputs a debounced level plus one-cycle press and release strobes.
//  - Sits between board push-buttons/switches and control FSMs; all channels in one clock domain.
// PARAMETERS
//  CLK_FREQ_MHZ    150   clk_i frequency, MHz
//  GLITCH_TIME_NS  100   min stable time accepted as a real transition, ns
//  KEY_CNT         4     number of independent channels, >=1
//  KEY_ACTIVE_LOW  0     1: key_i low = pressed (input inverted after sync)
//  LONG_PRESS_CYC  1000  held cycles before long-press strobe (LONG_PRESS_EN only)
// PORTS
//  clk_i               in   1        clock
//  rst_i               in   1        async reset, active-high
//  key_i               in   KEY_CNT  raw key inputs, asynchronous
//  key_state_o         out  KEY_CNT  debounced level, 1 = pressed
//  key_pressed_stb_o   out  KEY_CNT  1-cycle pulse on debounced 0->1
//  key_released_stb_o  out  KEY_CNT  1-cycle pulse on debounced 1->0
//  key_long_stb_o      out  KEY_CNT  1-cycle long-press pulse (0 without LONG_PRESS_EN)
// BEHAVIOUR
//  - GLITCH_CYC = max(1, GLITCH_TIME_NS*CLK_FREQ_MHZ/1000), integer division; 150/100 -> 15.
//  - Counter width $clog2(GLITCH_CYC+1); saturating, never wraps.
//  - Per channel: 2-flop synchronizer -> optional invert -> filter counter -> state reg.
//  - Filter:
//    - sync != state: cnt increments.
//    - sync == state: cnt clears to 0; any bounce restarts the count.
//    - sync != state with cnt == GLITCH_CYC-1: next edge flips state, clears cnt,
//      pulses the matching strobe in the same cycle state changes.
//  - Latency: input change stable from edge 0 -> state/strobe update at edge 2+GLITCH_CYC.
//  - Pulses shorter than GLITCH_CYC cycles (post-sync) produce no output activity.
//  - Strobes are exactly 1 cycle wide; press and release never both high on one channel.
//  - Channels fully independent; simultaneous events on any set of channels all reported.
//  - Reset (async assert, sync-deassert handled externally):
//    - sync flops load the released level; state, cnt and all strobes go to 0.
//    - Key held pressed across reset -> press strobe 2+GLITCH_CYC cycles after rst_i falls.
//    - Reset mid-count discards the partial count; no strobe.
// CONFIGURATION
//  - Macro MULTI_KEY_DEBOUNCER_LONG_PRESS_EN.
//  - Defined:
//    - per-channel hold counter, width $clog2(LONG_PRESS_CYC+1), runs while state==1;
//    - key_long_stb_o pulses once when it reaches LONG_PRESS_CYC, then saturates;
//    - at most one long pulse per press; counter clears when state returns to 0 or on reset.
//  - Undefined: no hold counter; key_long_stb_o tied to '0; port list unchanged.
// STRUCTURE
//  - debouncer_pkg:
//    - function glitch_cycles(freq_mhz, glitch_ns) returning max(1, ...);
//    - localparam-friendly width helper;
//    - typedef struct packed {state, press, release, long_press} key_evt_t.
//  - Sub-module debouncer_channel (one key: sync, filter, strobes, optional hold counter).
//  - Top instantiates KEY_CNT channels in a generate loop and packs outputs.
// TESTING (CLK_FREQ_MHZ=150, GLITCH_TIME_NS=100 -> GLITCH_CYC=15, KEY_CNT=4)
//  1. key_i[0] 0->1, held 40 cycles -> key_pressed_stb_o[0] high exactly at cycle 17, one cycle;
//     key_state_o[0]=1 from cycle 17.
//  2. key_i[1] 14-cycle high pulse, repeated with 1-cycle low gaps for 100 cycles
//     -> no strobes, key_state_o[1]=0.
//  3. Pressed key released, held low 20 cycles -> key_released_stb_o pulse at cycle 17,
//     state returns to 0.
//  4. All 4 keys rise on the same edge -> 4'b1111 on key_pressed_stb_o in one cycle;
//     KEY_ACTIVE_LOW=1 with key_i 1->0 gives same result.
//  5. rst_i asserted at count 10 of a press -> outputs 0 immediately;
//     key still high -> press strobe 17 cycles after rst_i deasserts.
//  6. LONG_PRESS_EN, LONG_PRESS_CYC=50: hold 200 cycles -> one key_long_stb_o pulse
//     50 cycles after press strobe; macro undefined -> stays 0.
//  - Random bench: reference model compares every output every cycle over 10k cycles.

Source files
------------

// File: rtl/multi_key_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// multi_key_debouncer_pkg
// Shared helpers and types for the multi-channel key debouncer.
//   glitch_cycles() : converts clock frequency and glitch time into a filter
//                     length in cycles, never less than 1.
//   cnt_width()     : bit width needed to hold a count of 0..max_val.
//   key_evt_t       : per-channel event bundle (level plus strobes).
// -----------------------------------------------------------------------------
package multi_key_debouncer_pkg;

  // Filter length in clock cycles; integer division, clamped to at least 1.
  function automatic int glitch_cycles(input int freq_mhz, input int glitch_ns);
    int cyc;
    cyc = (glitch_ns * freq_mhz) / 1000;
    if (cyc < 1) begin
      return 1;
    end else begin
      return cyc;
    end
  endfunction

  // Width of a counter that must reach max_val (max_val >= 1).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

  typedef struct packed {
    logic state;
    logic pressed;
    logic released;
    logic long_press;
  } key_evt_t;

endpackage

// File: rtl/multi_key_debouncer_channel.sv
// -----------------------------------------------------------------------------
// multi_key_debouncer_channel
// One debounced key: 2-flop synchronizer, optional polarity inversion,
// saturating glitch filter, registered level and 1-cycle press/release strobes.
// With MULTI_KEY_DEBOUNCER_LONG_PRESS_EN defined, a hold counter also produces
// one long-press strobe LONG_PRESS_CYC cycles after the press strobe.
// Ports:
//   clk  in  1          clock
//   rst  in  1          async reset, active-high
//   key  in  1          raw asynchronous key input
//   evt  out key_evt_t  registered level and strobes
// -----------------------------------------------------------------------------
module multi_key_debouncer_channel
  import multi_key_debouncer_pkg::*;
#(
  parameter int GLITCH_CYC     = 15,
  parameter bit KEY_ACTIVE_LOW = 1'b0,
  parameter int LONG_PRESS_CYC = 1000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     key,
  output key_evt_t evt
);

  localparam int              CNT_W    = cnt_width(GLITCH_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYC - 1);
  // Raw level of a released key; the synchronizer resets to it so that no
  // spurious transition is seen when reset is released.
  localparam logic            IDLE_LVL = KEY_ACTIVE_LOW;

  // Elaboration-time parameter sanity check.
  if (GLITCH_CYC < 1 || LONG_PRESS_CYC < 1) begin : g_param_err
    $error("multi_key_debouncer_channel: GLITCH_CYC and LONG_PRESS_CYC must be >= 1");
  end

  logic             sync1_r;
  logic             sync2_r;
  logic             level_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             state_r;
  logic             state_nxt_s;
  logic             press_r;
  logic             press_nxt_s;
  logic             rel_r;
  logic             rel_nxt_s;
  logic             long_s;

  // Two-flop synchronizer for the asynchronous key input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= IDLE_LVL;
      sync2_r <= IDLE_LVL;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
    end
  end

  // Normalise polarity so that 1 always means pressed.
  always_comb begin
    level_s = KEY_ACTIVE_LOW ? ~sync2_r : sync2_r;
  end

  // Glitch filter: count consecutive cycles of disagreement with the
  // debounced state; any agreement restarts the count. The count stops at
  // CNT_LAST because that cycle flips the state and clears it.
  always_comb begin
    cnt_nxt_s   = '0;
    state_nxt_s = state_r;
    press_nxt_s = 1'b0;
    rel_nxt_s   = 1'b0;
    if (level_s == state_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s   = '0;
      state_nxt_s = level_s;
      press_nxt_s = level_s;
      rel_nxt_s   = ~level_s;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Filter counter, debounced state and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      state_r <= 1'b0;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
      press_r <= press_nxt_s;
      rel_r   <= rel_nxt_s;
    end
  end

`ifdef MULTI_KEY_DEBOUNCER_LONG_PRESS_EN
  localparam int               HOLD_W    = cnt_width(LONG_PRESS_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYC);

  logic [HOLD_W-1:0] hold_r;
  logic              long_r;

  // Hold counter: runs while pressed, saturates at LONG_PRESS_CYC so the
  // long strobe fires only once per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
      long_r <= 1'b0;
    end else if (!state_r) begin
      hold_r <= '0;
      long_r <= 1'b0;
    end else if (hold_r != HOLD_LAST) begin
      hold_r <= hold_r + HOLD_W'(1);
      long_r <= (hold_r == (HOLD_LAST - HOLD_W'(1)));
    end else begin
      long_r <= 1'b0;
    end
  end

  // Long-press strobe comes straight from its register.
  always_comb begin
    long_s = long_r;
  end
`else
  // Long-press feature not built: strobe held low.
  always_comb begin
    long_s = 1'b0;
  end
`endif

  assign evt = '{state: state_r, pressed: press_r, released: rel_r, long_press: long_s};

endmodule

// File: rtl/multi_key_debouncer.sv
// -----------------------------------------------------------------------------
// multi_key_debouncer
// KEY_CNT independent key debouncers in one clock domain. Each channel
// synchronizes its raw key, rejects pulses shorter than GLITCH_TIME_NS and
// reports a debounced level plus 1-cycle press/release strobes.
// Optional feature macro: MULTI_KEY_DEBOUNCER_LONG_PRESS_EN (long-press strobe
// after LONG_PRESS_CYC held cycles; tied low when undefined).
// Ports:
//   clk_i               in   1        clock
//   rst_i               in   1        async reset, active-high
//   key_i               in   KEY_CNT  raw key inputs, asynchronous
//   key_state_o         out  KEY_CNT  debounced level, 1 = pressed
//   key_pressed_stb_o   out  KEY_CNT  1-cycle pulse on debounced 0->1
//   key_released_stb_o  out  KEY_CNT  1-cycle pulse on debounced 1->0
//   key_long_stb_o      out  KEY_CNT  1-cycle long-press pulse
// -----------------------------------------------------------------------------
module multi_key_debouncer
  import multi_key_debouncer_pkg::*;
#(
  parameter int CLK_FREQ_MHZ   = 150,
  parameter int GLITCH_TIME_NS = 100,
  parameter int KEY_CNT        = 4,
  parameter bit KEY_ACTIVE_LOW = 1'b0,
  parameter int LONG_PRESS_CYC = 1000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [KEY_CNT-1:0] key_i,
  output logic [KEY_CNT-1:0] key_state_o,
  output logic [KEY_CNT-1:0] key_pressed_stb_o,
  output logic [KEY_CNT-1:0] key_released_stb_o,
  output logic [KEY_CNT-1:0] key_long_stb_o
);

  localparam int GLITCH_CYC = glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);

  key_evt_t evt_s [KEY_CNT];

  for (genvar i = 0; i < KEY_CNT; i++) begin : g_chan
    multi_key_debouncer_channel #(
      .GLITCH_CYC     (GLITCH_CYC),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
      .LONG_PRESS_CYC (LONG_PRESS_CYC)
    ) u_chan (
      .clk (clk_i),
      .rst (rst_i),
      .key (key_i[i]),
      .evt (evt_s[i])
    );

    // Channel outputs are already registered; only repack per field here.
    assign key_state_o[i]        = evt_s[i].state;
    assign key_pressed_stb_o[i]  = evt_s[i].pressed;
    assign key_released_stb_o[i] = evt_s[i].released;
    assign key_long_stb_o[i]     = evt_s[i].long_press;
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_key_debouncer
// Directed bench for multi_key_debouncer (150 MHz, 100 ns -> 15-cycle filter,
// 4 keys). Two instances run in lock-step: one active-high, one active-low fed
// with the inverted keys; both must produce identical outputs.
// Timing reference: inputs change 1 time unit after an edge ("edge 0");
// outputs are sampled 1 time unit after edge N.
// -----------------------------------------------------------------------------
module tb_multi_key_debouncer;

  localparam int KEYS = 4;

`ifdef MULTI_KEY_DEBOUNCER_LONG_PRESS_EN
  localparam logic [KEYS-1:0] LONG_K0 = 4'b0001;
`else
  localparam logic [KEYS-1:0] LONG_K0 = 4'b0000;
`endif

  logic            clk;
  logic            rst;
  logic [KEYS-1:0] key;
  logic [KEYS-1:0] key_n;
  logic [KEYS-1:0] hi_state, hi_press, hi_rel, hi_long;
  logic [KEYS-1:0] lo_state, lo_press, lo_rel, lo_long;

  int checks = 0;
  int errors = 0;

  assign key_n = ~key;

  multi_key_debouncer #(
    .CLK_FREQ_MHZ(150), .GLITCH_TIME_NS(100), .KEY_CNT(KEYS),
    .KEY_ACTIVE_LOW(1'b0), .LONG_PRESS_CYC(50)
  ) dut_hi (
    .clk_i(clk), .rst_i(rst), .key_i(key),
    .key_state_o(hi_state), .key_pressed_stb_o(hi_press),
    .key_released_stb_o(hi_rel), .key_long_stb_o(hi_long)
  );

  multi_key_debouncer #(
    .CLK_FREQ_MHZ(150), .GLITCH_TIME_NS(100), .KEY_CNT(KEYS),
    .KEY_ACTIVE_LOW(1'b1), .LONG_PRESS_CYC(50)
  ) dut_lo (
    .clk_i(clk), .rst_i(rst), .key_i(key_n),
    .key_state_o(lo_state), .key_pressed_stb_o(lo_press),
    .key_released_stb_o(lo_rel), .key_long_stb_o(lo_long)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare all outputs of both instances against one expectation.
  task automatic check_out(input string tag, input logic [KEYS-1:0] e_state,
                           input logic [KEYS-1:0] e_press, input logic [KEYS-1:0] e_rel,
                           input logic [KEYS-1:0] e_long);
    check_eq({tag, ".hi_state"}, 32'(hi_state), 32'(e_state));
    check_eq({tag, ".hi_press"}, 32'(hi_press), 32'(e_press));
    check_eq({tag, ".hi_rel"},   32'(hi_rel),   32'(e_rel));
    check_eq({tag, ".hi_long"},  32'(hi_long),  32'(e_long));
    check_eq({tag, ".lo_state"}, 32'(lo_state), 32'(e_state));
    check_eq({tag, ".lo_press"}, 32'(lo_press), 32'(e_press));
    check_eq({tag, ".lo_rel"},   32'(lo_rel),   32'(e_rel));
    check_eq({tag, ".lo_long"},  32'(lo_long),  32'(e_long));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    key = 4'b0000;
    tick(3);
    check_out("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    tick(20);
    check_out("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 1 + 6: key0 press, strobe at edge 17, long strobe 50 cycles later.
    key[0] = 1'b1;
    tick(16);
    check_out("t1_e16", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("t1_e17", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tick(1);
    check_out("t1_e18", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick(48);
    check_out("t6_e66", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("t6_e67", 4'b0001, 4'b0000, 4'b0000, LONG_K0);
    tick(1);
    check_out("t6_e68", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 132; i++) begin
      tick(1);
      check_out("t6_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    end

    // 3: release key0, strobe at edge 17.
    key[0] = 1'b0;
    tick(16);
    check_out("t3_e16", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("t3_e17", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick(1);
    check_out("t3_e18", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(20);

    // 2: 14-high / 1-low bursts on key1 must be rejected entirely.
    for (int r = 0; r < 7; r++) begin
      key[1] = 1'b1;
      for (int c = 0; c < 14; c++) begin
        tick(1);
        check_out("t2_hi", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      key[1] = 1'b0;
      tick(1);
      check_out("t2_gap", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    tick(20);
    check_out("t2_end", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Boundary: a 15-cycle pulse is just long enough to be accepted.
    key[1] = 1'b1;
    tick(15);
    key[1] = 1'b0;
    tick(1);
    check_out("b15_e16", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("b15_e17", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    tick(14);
    check_out("b15_e31", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("b15_e32", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    tick(20);

    // 4: all keys rise together, then fall together.
    key = 4'b1111;
    tick(16);
    check_out("t4_e16", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("t4_e17", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    tick(1);
    check_out("t4_e18", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    key = 4'b0000;
    tick(17);
    check_out("t4_rel", 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    tick(1);
    check_out("t4_rel1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(20);

    // 5: key3 pressed and settled, key2 mid-count (count 10) when reset hits.
    key[3] = 1'b1;
    tick(20);
    check_out("t5_k3", 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    key[2] = 1'b1;
    tick(11);
    rst = 1'b1;
    #1;
    check_out("t5_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(2);
    check_out("t5_rst2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    tick(16);
    check_out("t5_e16", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    check_out("t5_e17", 4'b1100, 4'b1100, 4'b0000, 4'b0000);
    tick(1);
    check_out("t5_e18", 4'b1100, 4'b0000, 4'b0000, 4'b0000);
    key = 4'b0000;
    tick(17);
    check_out("t5_rel", 4'b0000, 4'b0000, 4'b1100, 4'b0000);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
